// File: rtl/kmeans_pkg.sv
// Shared constants, state encoding and header packing for the k-means pixel-stream source.
package kmeans_pkg;

  localparam int PIX_W     = 24;
  localparam int K_MAX     = 16;
  localparam int HDR_K_MSB = 23;
  localparam int HDR_K_LSB = 20;
  localparam int HDR_N_MSB = 19;
  localparam int HDR_N_W   = HDR_N_MSB + 1;
  localparam int HDR_K_W   = HDR_K_MSB - HDR_K_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } tx_state_e;

  function automatic logic k_legal(input logic [4:0] k);
    return (k != 5'd0) && (k <= 5'(K_MAX));
  endfunction

  // k=16 wraps to 4'hF in the header field, which is the intended "k-1" encoding.
  function automatic logic [PIX_W-1:0] make_header(input logic [4:0] k,
                                                   input logic [HDR_N_W-1:0] n);
    logic [PIX_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_K_MSB:HDR_K_LSB] = HDR_K_W'(k - 5'd1);
    hdr[HDR_N_MSB:0]         = n;
    return hdr;
  endfunction

endpackage

// File: rtl/kmeans_image_tx_if.sv
// 24-bit valid/ready pixel stream with the newImage header marker.
interface kmeans_image_tx_if;
  import kmeans_pkg::*;

  logic [PIX_W-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             newImage;

  modport master (output tx_data, output tx_valid, output newImage, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input newImage, output tx_ready);

endinterface

// File: rtl/tx_skid_fifo.sv
// Two-entry buffer whose head entry is a flop, so the stream data never passes through a mux.
module tx_skid_fifo
  import kmeans_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  output logic [PIX_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [PIX_W-1:0] head_q, head_d;
  logic [PIX_W-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop, do_push;

  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/kmeans_image_tx.sv
// Sends a K/N header then streams N pixels from a synchronous image RAM over valid/ready.
//   state  | meaning
//   IDLE   | waiting for a legal start
//   HEADER | header word on the bus, first RAM read issued
//   STREAM | prefetching pixels into the buffer, sending in address order
//   DONE   | one-cycle done pulse
module kmeans_image_tx
  import kmeans_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     num_pixels,
  input  logic [4:0]            k,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIX_W-1:0]      mem_rdata,
  kmeans_image_tx_if.master     tx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  tx_state_e        state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic              rvalid_q, rvalid_d;
  logic              newimg_q, newimg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic              fifo_push;
  logic [PIX_W-1:0]  fifo_din;
  logic              tx_valid;
  logic              pop;
  logic              accept;
  logic              rd_en;
  logic [2:0]        slots;

  tx_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (tx.tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The read strobe looks at this cycle's pop so a 2-entry buffer still sustains 1 pixel/cycle.
  always_comb begin
    tx_valid  = !fifo_empty;
    pop       = tx_valid && tx.tx_ready;
    accept    = (state_q == ST_IDLE) && start && k_legal(k);
    slots     = 3'(fifo_count) + 3'(rvalid_q) - 3'(pop);
    rd_en     = ((state_q == ST_HEADER) || (state_q == ST_STREAM)) &&
                (addr_q < n_q) && !fifo_full && (slots < 3'd2);
    fifo_push = accept || rvalid_q;
    fifo_din  = rvalid_q ? mem_rdata : make_header(k, HDR_N_W'(num_pixels));
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    addr_d   = addr_q;
    left_d   = left_q;
    newimg_d = newimg_q;
    err_d    = 1'b0;
    rvalid_d = rd_en;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (accept) begin
            state_d  = ST_HEADER;
            n_d      = num_pixels;
            left_d   = num_pixels;
            addr_d   = '0;
            newimg_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (pop) begin
          newimg_d = 1'b0;
          state_d  = (n_q == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pop) begin
          left_d = left_q - 1'b1;
          if (left_q == ADDR_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rd_en) addr_d = addr_q + 1'b1;
    busy_d = (state_d == ST_HEADER) || (state_d == ST_STREAM);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      addr_q   <= '0;
      left_q   <= '0;
      rvalid_q <= 1'b0;
      newimg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      rvalid_q <= rvalid_d;
      newimg_q <= newimg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign tx.tx_valid = tx_valid;
  assign tx.newImage = newimg_q;
  assign mem_rd_en   = rd_en;
  assign mem_addr    = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_kmeans_image_tx.sv
// Directed bench for kmeans_image_tx: timing, stalls, empty image, illegal k, reset and start-ignore.
module tb_kmeans_image_tx;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] num_pixels;
  logic [4:0]  k;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [23:0] mem_rdata;
  logic        busy, done, err;

  kmeans_image_tx_if tx_if();

  kmeans_image_tx #(.ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_pixels (num_pixels),
    .k          (k),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx         (tx_if),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] got[$];
  logic        gotn[$];
  int          done_cnt = 0;
  int          rd_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = '0;
  logic        prev_nimg = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image RAM: pixel at address i is 24'h100000 + i, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 24'h100000 + 24'(mem_addr);
  end

  // Negedge monitor: records accepted words and checks hold-while-stalled.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert (tx_if.tx_valid === 1'b1 && tx_if.tx_data === prev_data &&
                tx_if.newImage === prev_nimg)
        else begin
          errors++;
          $error("FAIL hold: observed v=%0b d=%06h n=%0b expected v=1 d=%06h n=%0b",
                 tx_if.tx_valid, tx_if.tx_data, tx_if.newImage, prev_data, prev_nimg);
        end
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      prev_nimg  = tx_if.newImage;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        got.push_back(tx_if.tx_data);
        gotn.push_back(tx_if.newImage);
      end
      if (done)      done_cnt++;
      if (mem_rd_en) rd_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [4:0] kv, input logic [15:0] nv);
    k          = kv;
    num_pixels = nv;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // mode 1 drives ready with the repeating pattern 1,0,0,1.
  task automatic run_to_done(input string tag, input int mode);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (mode == 1) tx_if.tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick();
      if (done) seen = 1'b1;
    end
    tx_if.tx_ready = 1'b1;
    tick();
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [23:0] hdr, input int n);
    chk({tag, " word_count"}, 32'(got.size()), 32'(n + 1));
    for (int i = 0; i <= n; i++) begin
      if (i < got.size()) begin
        chk($sformatf("%s word%0d", tag, i), 32'(got[i]),
            (i == 0) ? 32'(hdr) : 32'h100000 + 32'(i - 1));
        chk($sformatf("%s nimg%0d", tag, i), 32'(gotn[i]), (i == 0) ? 32'd1 : 32'd0);
      end
    end
  endtask

  int d0, r0;

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    k              = 5'd0;
    num_pixels     = 16'd0;
    tx_if.tx_ready = 1'b1;
    #1;
    chk("rst tx_valid", 32'(tx_if.tx_valid), 32'd0);
    chk("rst tx_data", 32'(tx_if.tx_data), 32'd0);
    chk("rst newImage", 32'(tx_if.newImage), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // Test 1: k=4, N=5, ready high, exact cycle timing.
    got.delete(); gotn.delete(); r0 = rd_cnt; d0 = done_cnt;
    go(5'd4, 16'd5);
    chk("t1 c1 valid", 32'(tx_if.tx_valid), 32'd1);
    chk("t1 c1 header", 32'(tx_if.tx_data), 32'h300005);
    chk("t1 c1 newImage", 32'(tx_if.newImage), 32'd1);
    chk("t1 c1 busy", 32'(busy), 32'd1);
    chk("t1 c1 rd_en", 32'(mem_rd_en), 32'd1);
    chk("t1 c1 addr", 32'(mem_addr), 32'd0);
    tick();
    chk("t1 c2 bubble", 32'(tx_if.tx_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1 c%0d valid", 3 + i), 32'(tx_if.tx_valid), 32'd1);
      chk($sformatf("t1 c%0d pixel", 3 + i), 32'(tx_if.tx_data), 32'h100000 + 32'(i));
      chk($sformatf("t1 c%0d done", 3 + i), 32'(done), 32'd0);
    end
    tick();
    chk("t1 c8 done", 32'(done), 32'd1);
    chk("t1 c8 busy", 32'(busy), 32'd0);
    tick();
    chk("t1 c9 done", 32'(done), 32'd0);
    check_stream("t1", 24'h300005, 5);
    chk("t1 reads", 32'(rd_cnt - r0), 32'd5);
    chk("t1 dones", 32'(done_cnt - d0), 32'd1);

    // Test 2: same image under ready pattern 1,0,0,1.
    got.delete(); gotn.delete(); d0 = done_cnt;
    go(5'd4, 16'd5);
    run_to_done("t2", 1);
    tick();
    check_stream("t2", 24'h300005, 5);
    chk("t2 dones", 32'(done_cnt - d0), 32'd1);

    // Test 3: k=16, N=0, header only, no RAM reads.
    got.delete(); gotn.delete(); r0 = rd_cnt;
    go(5'd16, 16'd0);
    chk("t3 header", 32'(tx_if.tx_data), 32'hF00000);
    chk("t3 newImage", 32'(tx_if.newImage), 32'd1);
    tick();
    chk("t3 done", 32'(done), 32'd1);
    tick();
    check_stream("t3", 24'hF00000, 0);
    chk("t3 reads", 32'(rd_cnt - r0), 32'd0);

    // Test 4: illegal k rejected, then a legal k=2 start.
    go(5'd0, 16'd3);
    chk("t4 k0 err", 32'(err), 32'd1);
    chk("t4 k0 valid", 32'(tx_if.tx_valid), 32'd0);
    chk("t4 k0 busy", 32'(busy), 32'd0);
    tick();
    chk("t4 k0 err clr", 32'(err), 32'd0);
    go(5'd17, 16'd3);
    chk("t4 k17 err", 32'(err), 32'd1);
    chk("t4 k17 valid", 32'(tx_if.tx_valid), 32'd0);
    chk("t4 k17 busy", 32'(busy), 32'd0);
    tick();
    got.delete(); gotn.delete();
    go(5'd2, 16'd3);
    chk("t4 k2 err", 32'(err), 32'd0);
    run_to_done("t4", 0);
    check_stream("t4", 24'h100003, 3);

    // Test 5: reset while pixel 2 of 8 is stalled, then a clean restart.
    go(5'd4, 16'd8);
    tick(); tick(); tick(); tick();
    chk("t5 pix2", 32'(tx_if.tx_data), 32'h100002);
    tx_if.tx_ready = 1'b0;
    tick(); tick();
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("t5 rst valid", 32'(tx_if.tx_valid), 32'd0);
    chk("t5 rst data", 32'(tx_if.tx_data), 32'd0);
    chk("t5 rst newImage", 32'(tx_if.newImage), 32'd0);
    chk("t5 rst busy", 32'(busy), 32'd0);
    chk("t5 rst rd_en", 32'(mem_rd_en), 32'd0);
    chk("t5 rst addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    tx_if.tx_ready = 1'b1;
    tick();
    chk("t5 no done", 32'(done_cnt - d0), 32'd0);
    got.delete(); gotn.delete();
    go(5'd4, 16'd8);
    run_to_done("t5", 0);
    check_stream("t5", 24'h300008, 8);

    // Test 6: start pulsed mid-stream with other k/N is ignored.
    got.delete(); gotn.delete(); d0 = done_cnt;
    go(5'd4, 16'd5);
    tick(); tick(); tick();
    go(5'd7, 16'd2);
    run_to_done("t6", 0);
    tick();
    check_stream("t6", 24'h300005, 5);
    chk("t6 dones", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
